// File: rtl/star_lr_extent_scan_pkg.sv
// Shared definitions for the star blob extent scanners: scan state encoding,
// default frame geometry and an address-width helper.
package star_lr_extent_scan_pkg;

  localparam int DEF_IMG_W     = 6;
  localparam int DEF_IMG_H     = 6;
  localparam int DEF_PIX_W     = 3;
  localparam int DEF_THRESHOLD = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_R_ISSUE  = 3'd2,
    ST_R_WAIT   = 3'd3,
    ST_L_ISSUE  = 3'd4,
    ST_L_WAIT   = 3'd5,
    ST_NEXT_ROW = 3'd6,
    ST_FIN      = 3'd7
  } scan_state_e;

  // Address bits needed for a w x h frame; never less than one bit.
  function automatic int addr_width(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/star_lr_extent_scan_if.sv
// Request/result handshake plus the shared frame-RAM read port of the
// left/right extent scanner.
interface star_lr_extent_scan_if #(
  parameter int XW    = 3,
  parameter int YW    = 3,
  parameter int AW    = 6,
  parameter int PIX_W = 3
);
  logic             start;
  logic [XW-1:0]    mid_x;
  logic [YW-1:0]    top_y;
  logic [YW-1:0]    bottom_y;
  logic [AW-1:0]    mem_addr;
  logic             mem_rd_en;
  logic [PIX_W-1:0] mem_q;
  logic             busy;
  logic             done;
  logic             err;
  logic [XW-1:0]    most_left;
  logic [XW-1:0]    most_right;

  modport master (
    output start, mid_x, top_y, bottom_y, mem_q,
    input  mem_addr, mem_rd_en, busy, done, err, most_left, most_right
  );

  modport slave (
    input  start, mid_x, top_y, bottom_y, mem_q,
    output mem_addr, mem_rd_en, busy, done, err, most_left, most_right
  );

endinterface

// File: rtl/star_lr_extent_scan_pix_addr_gen.sv
// Combinational (x,y) -> linear frame address, y*IMG_W + x, computed
// zero-extended at the full address width.
module pix_addr_gen #(
  parameter int IMG_W = 6,
  parameter int XW    = 3,
  parameter int YW    = 3,
  parameter int AW    = 6
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  output logic [AW-1:0] o_addr
);

  assign o_addr = AW'(i_y) * AW'(IMG_W) + AW'(i_x);

endmodule

// File: rtl/star_lr_extent_scan.sv
// Left/right extent finder for one star blob: scans rows top_y..bottom_y
// outward from mid_x and reports the outermost bright columns.
//
// state    | meaning
// IDLE     | waiting for start
// INIT     | request latched, first row armed
// R_ISSUE  | read pixel right of/at seed
// R_WAIT   | wait RD_LAT, evaluate right pixel
// L_ISSUE  | read pixel left of seed
// L_WAIT   | wait RD_LAT, evaluate left pixel
// NEXT_ROW | advance row or finish
// FIN      | result valid (done=1), accepts start
module star_lr_extent_scan
  import star_lr_extent_scan_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int XW        = $clog2(IMG_W),
  parameter int YW        = $clog2(IMG_H),
  parameter int AW        = addr_width(IMG_W, IMG_H),
  parameter int PIX_W     = DEF_PIX_W,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int RD_LAT    = 1
) (
  input logic                  clk,
  input logic                  resetn,
  star_lr_extent_scan_if.slave bus
);

  localparam int            WW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [YW:0]   Y_LIM  = (YW+1)'(IMG_H);
  localparam logic [XW:0]   X_LIM  = (XW+1)'(IMG_W);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);

  scan_state_e   r_state, w_state_nxt;
  logic [XW-1:0] r_x, w_x_nxt;
  logic [YW-1:0] r_y, w_y_nxt;
  logic [XW-1:0] r_mid_x, w_mid_x_nxt;
  logic [YW-1:0] r_bot_y, w_bot_y_nxt;
  logic [XW-1:0] r_ml, w_ml_nxt;
  logic [XW-1:0] r_mr, w_mr_nxt;
  logic          r_err, w_err_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;

  logic          w_bad_in;
  logic          w_bright;
  logic          w_wait_tc;
  logic [AW-1:0] w_addr;

  assign w_bad_in  = (bus.top_y > bus.bottom_y) ||
                     ({1'b0, bus.bottom_y} >= Y_LIM) ||
                     ({1'b0, bus.mid_x} >= X_LIM);
  assign w_bright  = bus.mem_q > PIX_W'(THRESHOLD);
  assign w_wait_tc = (r_wait == '0);

  pix_addr_gen #(
    .IMG_W (IMG_W),
    .XW    (XW),
    .YW    (YW),
    .AW    (AW)
  ) u_addr (
    .i_x    (r_x),
    .i_y    (r_y),
    .o_addr (w_addr)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_mid_x <= '0;
      r_bot_y <= '0;
      r_ml    <= '0;
      r_mr    <= '0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_mid_x <= w_mid_x_nxt;
      r_bot_y <= w_bot_y_nxt;
      r_ml    <= w_ml_nxt;
      r_mr    <= w_mr_nxt;
      r_err   <= w_err_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_mid_x_nxt = r_mid_x;
    w_bot_y_nxt = r_bot_y;
    w_ml_nxt    = r_ml;
    w_mr_nxt    = r_mr;
    w_err_nxt   = r_err;
    w_wait_nxt  = r_wait;

    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (bus.start) begin
          w_mid_x_nxt = bus.mid_x;
          w_bot_y_nxt = bus.bottom_y;
          if (w_bad_in) begin
            // Bad request finishes immediately with zeroed extents.
            w_state_nxt = ST_FIN;
            w_err_nxt   = 1'b1;
            w_ml_nxt    = '0;
            w_mr_nxt    = '0;
          end else begin
            w_state_nxt = ST_INIT;
            w_err_nxt   = 1'b0;
            w_x_nxt     = bus.mid_x;
            w_y_nxt     = bus.top_y;
            w_ml_nxt    = bus.mid_x;
            w_mr_nxt    = bus.mid_x;
          end
        end
      end

      ST_INIT: w_state_nxt = ST_R_ISSUE;

      ST_R_ISSUE: begin
        w_wait_nxt  = WW'(RD_LAT - 1);
        w_state_nxt = ST_R_WAIT;
      end

      ST_R_WAIT: begin
        if (!w_wait_tc) begin
          w_wait_nxt = r_wait - WW'(1);
        end else begin
          if (w_bright && (r_x > r_mr)) w_mr_nxt = r_x;
          if (w_bright && (r_x != X_LAST)) begin
            w_x_nxt     = r_x + XW'(1);
            w_state_nxt = ST_R_ISSUE;
          end else if ((!w_bright && (r_x == r_mid_x)) || (r_mid_x == '0)) begin
            // Empty row at the seed, or nothing exists left of column 0.
            w_state_nxt = ST_NEXT_ROW;
          end else begin
            w_x_nxt     = r_mid_x - XW'(1);
            w_state_nxt = ST_L_ISSUE;
          end
        end
      end

      ST_L_ISSUE: begin
        w_wait_nxt  = WW'(RD_LAT - 1);
        w_state_nxt = ST_L_WAIT;
      end

      ST_L_WAIT: begin
        if (!w_wait_tc) begin
          w_wait_nxt = r_wait - WW'(1);
        end else if (w_bright) begin
          if (r_x < r_ml) w_ml_nxt = r_x;
          if (r_x == '0) begin
            w_state_nxt = ST_NEXT_ROW;
          end else begin
            w_x_nxt     = r_x - XW'(1);
            w_state_nxt = ST_L_ISSUE;
          end
        end else begin
          w_state_nxt = ST_NEXT_ROW;
        end
      end

      ST_NEXT_ROW: begin
        if (r_y == r_bot_y) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_y_nxt     = r_y + YW'(1);
          w_x_nxt     = r_mid_x;
          w_state_nxt = ST_R_ISSUE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign bus.done       = (r_state == ST_FIN);
  assign bus.err        = r_err;
  assign bus.most_left  = r_ml;
  assign bus.most_right = r_mr;
  assign bus.mem_rd_en  = (r_state == ST_R_ISSUE) || (r_state == ST_L_ISSUE);
  assign bus.mem_addr   = w_addr;

endmodule

// File: tb/tb_star_lr_extent_scan.sv
// Bench for star_lr_extent_scan: two instances (RD_LAT 1 and 2) share a 6x6
// frame; a row-by-row behavioural model predicts reads, latency and extents.
module tb_star_lr_extent_scan;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int AW = 6;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  star_lr_extent_scan_if #(.XW(XW), .YW(YW), .AW(AW), .PIX_W(PW)) bus1 ();
  star_lr_extent_scan_if #(.XW(XW), .YW(YW), .AW(AW), .PIX_W(PW)) bus2 ();

  star_lr_extent_scan #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .THRESHOLD(0), .RD_LAT(1)
  ) dut1 (.clk(clk), .resetn(resetn), .bus(bus1.slave));

  star_lr_extent_scan #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .THRESHOLD(0), .RD_LAT(2)
  ) dut2 (.clk(clk), .resetn(resetn), .bus(bus2.slave));

  // Frame RAM models: data appears RD_LAT cycles after issue, junk otherwise.
  logic [PW-1:0] frame [W*H];
  logic [PW-1:0] p1, p2a, p2b;
  always @(posedge clk) begin
    p1  <= bus1.mem_rd_en ? frame[bus1.mem_addr] : PW'($urandom);
    p2a <= bus2.mem_rd_en ? frame[bus2.mem_addr] : PW'($urandom);
    p2b <= p2a;
  end
  assign bus1.mem_q = p1;
  assign bus2.mem_q = p2b;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int rd_cnt1 = 0;
  int rd_cnt2 = 0;
  int q1[$];
  int q2[$];
  int exp_ml, exp_mr, exp_err, exp_n, exp_rows;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit bright(input int x, input int y);
    return frame[y*W + x] > 0;
  endfunction

  task automatic push_rd(input int a);
    q1.push_back(a);
    q2.push_back(a);
    exp_n++;
  endtask

  // Expected read sequence and extents from the row-scan rules.
  task automatic model(input int mid, input int top, input int bot);
    q1.delete();
    q2.delete();
    exp_n = 0;
    exp_rows = 0;
    if (top > bot || bot >= H || mid >= W) begin
      exp_err = 1; exp_ml = 0; exp_mr = 0;
      return;
    end
    exp_err = 0; exp_ml = mid; exp_mr = mid;
    for (int y = top; y <= bot; y++) begin
      exp_rows++;
      for (int x = mid; x < W; x++) begin
        push_rd(y*W + x);
        if (!bright(x, y)) break;
        if (x > exp_mr) exp_mr = x;
      end
      if (bright(mid, y)) begin
        for (int x = mid - 1; x >= 0; x--) begin
          push_rd(y*W + x);
          if (!bright(x, y)) break;
          if (x < exp_ml) exp_ml = x;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && resetn) begin
      check("bsy_done1", int'(bus1.busy & bus1.done), 0);
      check("bsy_done2", int'(bus2.busy & bus2.done), 0);
      if (bus1.mem_rd_en) begin
        rd_cnt1++;
        if (q1.size() == 0) check("rd1_extra", int'(bus1.mem_addr), -1);
        else check("rd1_addr", int'(bus1.mem_addr), q1.pop_front());
      end
      if (bus2.mem_rd_en) begin
        rd_cnt2++;
        if (q2.size() == 0) check("rd2_extra", int'(bus2.mem_addr), -1);
        else check("rd2_addr", int'(bus2.mem_addr), q2.pop_front());
      end
    end
  end

  task automatic drive(input bit s, input int mid, input int top, input int bot);
    bus1.start = s; bus1.mid_x = XW'(mid); bus1.top_y = YW'(top); bus1.bottom_y = YW'(bot);
    bus2.start = s; bus2.mid_x = XW'(mid); bus2.top_y = YW'(top); bus2.bottom_y = YW'(bot);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < W*H; i++) frame[i] = '0;
  endtask

  task automatic set_px(input int x, input int y);
    frame[y*W + x] = 3'd5;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy1"}, int'(bus1.busy), 0);
    check({tag, "_done1"}, int'(bus1.done), 0);
    check({tag, "_err1"},  int'(bus1.err), 0);
    check({tag, "_ml1"},   int'(bus1.most_left), 0);
    check({tag, "_mr1"},   int'(bus1.most_right), 0);
    check({tag, "_rd1"},   int'(bus1.mem_rd_en), 0);
    check({tag, "_addr1"}, int'(bus1.mem_addr), 0);
    check({tag, "_busy2"}, int'(bus2.busy), 0);
    check({tag, "_done2"}, int'(bus2.done), 0);
    check({tag, "_rd2"},   int'(bus2.mem_rd_en), 0);
  endtask

  task automatic run_scan(input string tag, input int mid, input int top, input int bot,
                          input bit poke_in);
    int k, k1, k2, c1, c2;
    bit poke;
    model(mid, top, bot);
    poke = poke_in && (exp_err == 0);
    c1 = rd_cnt1;
    c2 = rd_cnt2;
    @(negedge clk);
    drive(1'b1, mid, top, bot);
    @(negedge clk);
    drive(1'b0, mid, top, bot);
    if (exp_err == 0) begin
      check({tag, "_busy_go"}, int'(bus1.busy), 1);
      check({tag, "_done_clr"}, int'(bus1.done), 0);
    end
    k = 1; k1 = 0; k2 = 0;
    while ((k1 == 0 || k2 == 0) && k < 3000) begin
      if (k1 == 0 && bus1.done) k1 = k;
      if (k2 == 0 && bus2.done) k2 = k;
      if (k1 == 0 || k2 == 0) begin
        if (poke && k == 3) drive(1'b1, 0, 5, 0);
        else if (poke && k == 4) drive(1'b0, 0, 5, 0);
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_lat1"}, k1, exp_err ? 1 : 2 + exp_n*2 + exp_rows);
    check({tag, "_lat2"}, k2, exp_err ? 1 : 2 + exp_n*3 + exp_rows);
    repeat (2) @(negedge clk);
    check({tag, "_done1"}, int'(bus1.done), 1);
    check({tag, "_busy1"}, int'(bus1.busy), 0);
    check({tag, "_err1"},  int'(bus1.err), exp_err);
    check({tag, "_ml1"},   int'(bus1.most_left), exp_ml);
    check({tag, "_mr1"},   int'(bus1.most_right), exp_mr);
    check({tag, "_done2"}, int'(bus2.done), 1);
    check({tag, "_err2"},  int'(bus2.err), exp_err);
    check({tag, "_ml2"},   int'(bus2.most_left), exp_ml);
    check({tag, "_mr2"},   int'(bus2.most_right), exp_mr);
    check({tag, "_nrd1"},  rd_cnt1 - c1, exp_n);
    check({tag, "_nrd2"},  rd_cnt2 - c2, exp_n);
  endtask

  task automatic load_box();
    clear_frame();
    for (int y = 1; y <= 3; y++)
      for (int x = 2; x <= 4; x++) set_px(x, y);
  endtask

  initial begin
    int k, mid, top, bot;
    drive(1'b0, 0, 0, 0);
    clear_frame();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    resetn = 1'b1;
    chk_en = 1'b1;

    // Box, with a stray start pulse mid-scan.
    load_box();
    run_scan("box", 3, 1, 3, 1'b1);
    check("box_model_n", exp_n, 15);
    check("box_ml_lit", int'(bus1.most_left), 2);
    check("box_mr_lit", int'(bus1.most_right), 4);
    check("box2_mr_lit", int'(bus2.most_right), 4);

    // Ragged rows, right edge reached on row 2, dark seed on row 3.
    clear_frame();
    set_px(3, 1);
    for (int x = 1; x <= 5; x++) set_px(x, 2);
    run_scan("ragged", 3, 1, 3, 1'b0);
    check("ragged_model_n", exp_n, 10);
    check("ragged_ml_lit", int'(bus1.most_left), 1);
    check("ragged_mr_lit", int'(bus1.most_right), 5);

    // Left border, seed at column 0.
    clear_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x <= 2; x++) set_px(x, y);
    run_scan("lborder", 0, 0, 5, 1'b0);
    check("lborder_model_n", exp_n, 24);
    check("lborder_ml_lit", int'(bus1.most_left), 0);
    check("lborder_mr_lit", int'(bus1.most_right), 2);

    // Invalid range.
    run_scan("invalid", 3, 4, 2, 1'b0);
    check("invalid_err_lit", int'(bus1.err), 1);
    check("invalid_ml_lit", int'(bus1.most_left), 0);
    check("invalid_n_lit", exp_n, 0);

    // Reset while waiting on the first read of row 2.
    load_box();
    model(3, 1, 3);
    @(negedge clk);
    drive(1'b1, 3, 1, 3);
    @(negedge clk);
    drive(1'b0, 3, 1, 3);
    k = 0;
    while (!(bus1.mem_rd_en && bus1.mem_addr == AW'(15)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_row2", int'(k < 200), 1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    resetn = 1'b1;
    run_scan("box_again", 3, 1, 3, 1'b1);
    check("box_again_ml_lit", int'(bus1.most_left), 2);
    check("box_again_mr_lit", int'(bus1.most_right), 4);

    // Random frames and requests.
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < W*H; i++)
        frame[i] = ($urandom_range(0, 99) < 60) ? PW'($urandom_range(1, 7)) : '0;
      if ($urandom_range(0, 4) == 0) begin
        mid = $urandom_range(0, 7); top = $urandom_range(0, 7); bot = $urandom_range(0, 7);
      end else begin
        mid = $urandom_range(0, W-1); top = $urandom_range(0, H-1); bot = $urandom_range(top, H-1);
      end
      run_scan("rand", mid, top, bot, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
